// File: rtl/obuftds_pkg.sv
// obuftds_pkg: shared types and constants for the tri-state differential output bank.
// Holds the sequencer state encoding, the PRBS7 seed/taps and the counter-width helper.
// The optional PRBS7 test-pattern source is enabled by defining OBUFTDS_PRBS_EN.
package obuftds_pkg;

  // Sequencer states. The numeric values are visible on the ST port and must stay fixed.
  typedef enum logic [1:0] {
    ST_HIZ   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // PRBS7 polynomial x^7 + x^6 + 1: feedback is the XOR of bits 6 and 5.
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  // Width needed to hold the larger of the two window reloads; never narrower than 1 bit.
  function automatic int cnt_w(input int wake_cyc, input int drain_cyc);
    int max_cyc;
    int w;
    max_cyc = (wake_cyc > drain_cyc) ? wake_cyc : drain_cyc;
    w = $clog2(max_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/obuftds_prbs7.sv
// obuftds_prbs7: Fibonacci PRBS7 generator (x^7 + x^6 + 1) for the output bank test mode.
// Only instantiated when OBUFTDS_PRBS_EN is defined. Reloads the all-ones seed on R and
// advances one step on each cycle where adv is high, so the sequence tracks captured words.
module obuftds_prbs7
  import obuftds_pkg::*;
(
  input  logic       C,
  input  logic       R,
  input  logic       adv,
  output logic [6:0] q
);

  logic [6:0] lfsr_reg;
  logic [6:0] lfsr_next;
  logic       feedback;

  // Next value: shift left, feeding the tap XOR into bit 0; hold while not advancing.
  always_comb begin
    feedback  = lfsr_reg[PRBS7_TAP_HI] ^ lfsr_reg[PRBS7_TAP_LO];
    lfsr_next = lfsr_reg;
    if (adv) begin
      lfsr_next = {lfsr_reg[5:0], feedback};
    end
  end

  // Shift register with synchronous reseed.
  always_ff @(posedge C) begin
    if (R) begin
      lfsr_reg <= PRBS7_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign q = lfsr_reg;

endmodule

// File: rtl/obuftds_bank.sv
// obuftds_bank: registered WIDTH-channel tri-state differential output bank.
// A HIZ -> WAKE -> DRIVE -> DRAIN -> HIZ sequencer frames each burst with idle-level
// windows so the far-end receiver sees a clean line before and after data. GTS releases
// every pad combinationally and forces the sequencer home on the next edge.
// Define OBUFTDS_PRBS_EN to add the PRBS port and a PRBS7 pattern source for link bring-up.
module obuftds_bank
  import obuftds_pkg::*;
#(
  parameter int   WIDTH     = 4,
  parameter int   WAKE_CYC  = 3,
  parameter int   DRAIN_CYC = 2,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             GTS,
  input  logic             T,
  input  logic [WIDTH-1:0] TCH,
  input  logic [WIDTH-1:0] I,
`ifdef OBUFTDS_PRBS_EN
  input  logic             PRBS,
`endif
  // Pad-facing outputs are nets because they carry high-impedance values.
  output wire  [WIDTH-1:0] O,
  output wire  [WIDTH-1:0] OB,
  output logic             RDY,
  output logic [1:0]       ST
);

  localparam int CNT_W      = cnt_w(WAKE_CYC, DRAIN_CYC);
  // Reload values; a zero-length window never loads the counter, so clamp to keep them legal.
  localparam int WAKE_LOAD  = (WAKE_CYC  > 0) ? WAKE_CYC  - 1 : 0;
  localparam int DRAIN_LOAD = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

  state_e             state_reg;
  state_e             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [WIDTH-1:0]   data_reg;
  logic [WIDTH-1:0]   data_next;
  logic [WIDTH-1:0]   load_word;
  logic [WIDTH-1:0]   drv_en;
  logic [WIDTH-1:0]   drv_val;
  logic               rdy;

  // Data is only accepted while the bank is in DRIVE.
  assign rdy = (state_reg == ST_DRIVE);
  assign RDY = rdy;
  assign ST  = state_reg;

  // ------------------------------------------------------------------
  // Data source selection
  // ------------------------------------------------------------------
`ifdef OBUFTDS_PRBS_EN
  logic [6:0]       prbs_q;
  logic [WIDTH-1:0] prbs_word;

  obuftds_prbs7 u_prbs7 (
    .C   (C),
    .R   (R),
    .adv (rdy),
    .q   (prbs_q)
  );

  // Channels beyond 7 reuse the pattern bits cyclically.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prbs_map
    assign prbs_word[gi] = prbs_q[gi % 7];
  end

  assign load_word = PRBS ? prbs_word : I;
`else
  assign load_word = I;
`endif

  // ------------------------------------------------------------------
  // Sequencer
  // ------------------------------------------------------------------

  // Next-state and window counter; the counter only decrements when nonzero, so it never wraps.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (GTS) begin
      state_next = ST_HIZ;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_HIZ: begin
          if (!T) begin
            if (WAKE_CYC == 0) begin
              state_next = ST_DRIVE;
              cnt_next   = '0;
            end else begin
              state_next = ST_WAKE;
              cnt_next   = CNT_W'(WAKE_LOAD);
            end
          end
        end
        ST_WAKE: begin
          // Releasing during wake skips drain: no data ever reached the line.
          if (T) begin
            state_next = ST_HIZ;
            cnt_next   = '0;
          end else if (cnt_reg == '0) begin
            state_next = ST_DRIVE;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (T) begin
            if (DRAIN_CYC == 0) begin
              state_next = ST_HIZ;
              cnt_next   = '0;
            end else begin
              state_next = ST_DRAIN;
              cnt_next   = CNT_W'(DRAIN_LOAD);
            end
          end
        end
        ST_DRAIN: begin
          // Drain always runs to completion; T is looked at again only from HIZ.
          if (cnt_reg == '0) begin
            state_next = ST_HIZ;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_HIZ;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Sequencer state and counter registers; R wins over GTS and T.
  always_ff @(posedge C) begin
    if (R) begin
      state_reg <= ST_HIZ;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ------------------------------------------------------------------
  // Data register
  // ------------------------------------------------------------------

  // Capture on every ready edge, otherwise hold the last word.
  always_comb begin
    data_next = data_reg;
    if (rdy) begin
      data_next = load_word;
    end
  end

  // Output data register, cleared by reset.
  always_ff @(posedge C) begin
    if (R) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  // ------------------------------------------------------------------
  // Per-channel differential tri-state drivers
  // ------------------------------------------------------------------

  // Both legs share one enable, so a channel is never driven on one side only.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    assign drv_en[gi]  = !GTS &&
                         ((state_reg == ST_WAKE)  ||
                          (state_reg == ST_DRAIN) ||
                          ((state_reg == ST_DRIVE) && !TCH[gi]));
    assign drv_val[gi] = (state_reg == ST_DRIVE) ? data_reg[gi] : IDLE_LVL;
    assign O[gi]       = drv_en[gi] ?  drv_val[gi] : 1'bz;
    assign OB[gi]      = drv_en[gi] ? ~drv_val[gi] : 1'bz;
  end

endmodule

// File: tb/tb_obuftds_bank.sv
// tb_obuftds_bank: self-checking bench for obuftds_bank (WIDTH=4, WAKE=3, DRAIN=2, IDLE=0).
// A cycle model of the bank pushes expected observations into a scoreboard queue each
// time stimulus is applied; they are popped and compared when the DUT outputs are sampled.
// Directed scenarios are followed by a short constrained-random run.
module tb_obuftds_bank;

  localparam int   WIDTH     = 4;
  localparam int   WAKE_CYC  = 3;
  localparam int   DRAIN_CYC = 2;
  localparam logic IDLE_LVL  = 1'b0;

  localparam logic [1:0] S_HIZ   = 2'd0;
  localparam logic [1:0] S_WAKE  = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

`ifdef OBUFTDS_PRBS_EN
  localparam bit HAS_PRBS = 1'b1;
`else
  localparam bit HAS_PRBS = 1'b0;
`endif

  logic             clk_c = 1'b0;
  logic             r;
  logic             gts;
  logic             t;
  logic [WIDTH-1:0] tch;
  logic [WIDTH-1:0] din;
  logic             prbs_sel;
  wire  [WIDTH-1:0] o_w;
  wire  [WIDTH-1:0] ob_w;
  logic             rdy;
  logic [1:0]       st;

  always #5 clk_c = ~clk_c;

  obuftds_bank #(
    .WIDTH     (WIDTH),
    .WAKE_CYC  (WAKE_CYC),
    .DRAIN_CYC (DRAIN_CYC),
    .IDLE_LVL  (IDLE_LVL)
  ) dut (
    .C   (clk_c),
    .R   (r),
    .GTS (gts),
    .T   (t),
    .TCH (tch),
    .I   (din),
`ifdef OBUFTDS_PRBS_EN
    .PRBS(prbs_sel),
`endif
    .O   (o_w),
    .OB  (ob_w),
    .RDY (rdy),
    .ST  (st)
  );

  // Observation: state, ready, per-channel "driven" flag and driven value.
  typedef struct packed {
    logic [1:0]       st;
    logic             rdy;
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] val;
  } obs_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  obs_t  exp_q[$];
  string tag_q[$];
  obs_t  comb_obs;

  // Reference model state.
  logic [1:0]       m_st;
  int               m_cnt;
  logic [WIDTH-1:0] m_data;
  logic [6:0]       m_prbs;
  bit               m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A channel counts as driven when its legs differ; released legs read identical.
  function automatic obs_t dut_obs();
    obs_t o;
    o.st  = st;
    o.rdy = rdy;
    for (int k = 0; k < WIDTH; k++) begin
      o.en[k]  = (o_w[k] !== ob_w[k]);
      o.val[k] = o.en[k] ? o_w[k] : 1'b0;
    end
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t e;
    e.st  = m_st;
    e.rdy = (m_st == S_DRIVE);
    for (int k = 0; k < WIDTH; k++) begin
      e.en[k]  = !gts && ((m_st == S_WAKE) || (m_st == S_DRAIN) ||
                          ((m_st == S_DRIVE) && !tch[k]));
      e.val[k] = e.en[k] ? ((m_st == S_DRIVE) ? m_data[k] : IDLE_LVL) : 1'b0;
    end
    return e;
  endfunction

  // One rising edge of the behavioural model, using the inputs present at that edge.
  task automatic model_step();
    logic [WIDTH-1:0] pw;
    if (r) begin
      m_st   = S_HIZ;
      m_cnt  = 0;
      m_data = '0;
      m_prbs = 7'h7F;
    end else begin
      if (m_st == S_DRIVE) begin
        for (int k = 0; k < WIDTH; k++) pw[k] = m_prbs[k % 7];
        m_data = (HAS_PRBS && prbs_sel) ? pw : din;
        m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
      end
      if (gts) begin
        m_st  = S_HIZ;
        m_cnt = 0;
      end else begin
        case (m_st)
          S_HIZ:   if (!t) begin m_st = S_WAKE; m_cnt = WAKE_CYC - 1; end
          S_WAKE:  if (t) begin m_st = S_HIZ; m_cnt = 0; end
                   else if (m_cnt == 0) m_st = S_DRIVE;
                   else m_cnt--;
          S_DRIVE: if (t) begin m_st = S_DRAIN; m_cnt = DRAIN_CYC - 1; end
          default: if (m_cnt == 0) m_st = S_HIZ;
                   else m_cnt--;
        endcase
      end
    end
  endtask

  task automatic sb_push(input string tag);
    exp_q.push_back(model_obs());
    tag_q.push_back($sformatf("%s@%0d", tag, cyc));
  endtask

  task automatic sb_pop_cmp();
    obs_t  e;
    string tg;
    obs_t  o;
    o  = dut_obs();
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    chk(tg, 32'(o), 32'(e));
  endtask

  // Apply inputs, check the combinational response, clock once, check the registered response.
  task automatic cycle(input string tag, input logic rr, input logic gg, input logic tt,
                       input logic [WIDTH-1:0] tc, input logic [WIDTH-1:0] dd,
                       input logic pp);
    r = rr; gts = gg; t = tt; tch = tc; din = dd; prbs_sel = pp;
    #1;
    comb_obs = dut_obs();
    if (m_valid) begin
      sb_push({tag, "_comb"});
      sb_pop_cmp();
    end
    @(posedge clk_c);
    model_step();
    m_valid = 1'b1;
    cyc++;
    @(negedge clk_c);
    sb_push(tag);
    sb_pop_cmp();
  endtask

  initial begin
    obs_t o;
    int   wake_seen;
    int   rdy_cnt;
    bit   got_rdy;

    r = 1'b1; gts = 1'b0; t = 1'b1; tch = '0; din = '0; prbs_sel = 1'b0;
    m_st = S_HIZ; m_cnt = 0; m_data = '0; m_prbs = 7'h7F;

    // Reset, then idle with T held high.
    cycle("rst", 1, 0, 1, 4'h0, 4'h0, 0);
    cycle("rst", 1, 0, 1, 4'h0, 4'h0, 0);
    o = dut_obs();
    chk("rst_st", 32'(o.st), 32'(S_HIZ));
    chk("rst_rdy", 32'(o.rdy), 0);
    chk("rst_en", 32'(o.en), 0);
    for (int n = 0; n < 3; n++) cycle("idle", 0, 0, 1, 4'h0, 4'h0, 0);
    chk("idle_st", 32'(st), 32'(S_HIZ));

    // Enable: expect exactly three idle-level cycles before ready, bounded wait.
    wake_seen = 0;
    got_rdy   = 1'b0;
    for (int n = 0; n < 10 && !got_rdy; n++) begin
      cycle("wake", 0, 0, 0, 4'h0, 4'hA, 0);
      o = dut_obs();
      if (o.rdy) got_rdy = 1'b1;
      else if (o.st == S_WAKE && o.en == 4'hF && o.val == 4'h0) wake_seen++;
    end
    chk("wake_len", 32'(wake_seen), 3);
    chk("wake_rdy", 32'(got_rdy), 1);
    chk("pre_data", 32'({o.en, o.val}), 32'h00F0);
    cycle("data", 0, 0, 0, 4'h0, 4'hA, 0);
    o = dut_obs();
    chk("first_data", 32'({o.en, o.val}), 32'h00FA);

    // Per-channel mask in DRIVE.
    cycle("tch", 0, 0, 0, 4'b0010, 4'hF, 0);
    o = dut_obs();
    chk("tch_mask", 32'({o.en, o.val}), 32'h00DD);
    foreach (din[k]) begin end
    cycle("pat", 0, 0, 0, 4'h0, 4'h5, 0);
    cycle("pat", 0, 0, 0, 4'h0, 4'h3, 0);
    cycle("pat", 0, 0, 0, 4'h0, 4'hC, 0);
    o = dut_obs();
    chk("pat_c", 32'(o.val), 32'hC);

    // Disable: drain ignores TCH and a T=0 pulse, then HIZ, then re-enable.
    cycle("drn", 0, 0, 1, 4'hF, 4'h6, 0);
    o = dut_obs();
    chk("drain1", 32'({o.st, o.en, o.val}), 32'({S_DRAIN, 4'hF, 4'h0}));
    cycle("drn", 0, 0, 0, 4'hF, 4'h6, 0);
    chk("drain2_st", 32'(st), 32'(S_DRAIN));
    cycle("drn", 0, 0, 0, 4'h0, 4'h6, 0);
    o = dut_obs();
    chk("drain_done", 32'({o.st, o.en}), 32'({S_HIZ, 4'h0}));
    cycle("rewake", 0, 0, 0, 4'h0, 4'h9, 0);
    chk("rewake_st", 32'(st), 32'(S_WAKE));
    for (int n = 0; n < 4; n++) cycle("rewake", 0, 0, 0, 4'h0, 4'h9, 0);
    chk("redrive_st", 32'(st), 32'(S_DRIVE));

    // GTS mid-DRIVE: released in the same cycle, HIZ after the edge.
    cycle("gts", 0, 1, 0, 4'h0, 4'h3, 0);
    chk("gts_comb_en", 32'(comb_obs.en), 0);
    chk("gts_st", 32'(st), 32'(S_HIZ));

    // Abort during WAKE: back to HIZ with no ready pulse.
    cycle("hold", 0, 0, 1, 4'h0, 4'h3, 0);
    rdy_cnt = 0;
    cycle("abort", 0, 0, 0, 4'h0, 4'h3, 0);
    rdy_cnt += int'(rdy) + int'(comb_obs.rdy);
    cycle("abort", 0, 0, 0, 4'h0, 4'h3, 0);
    rdy_cnt += int'(rdy) + int'(comb_obs.rdy);
    cycle("abort", 0, 0, 1, 4'h0, 4'h3, 0);
    rdy_cnt += int'(rdy) + int'(comb_obs.rdy);
    chk("abort_st", 32'(st), 32'(S_HIZ));
    cycle("abort", 0, 0, 1, 4'h0, 4'h3, 0);
    rdy_cnt += int'(rdy) + int'(comb_obs.rdy);
    chk("abort_no_rdy", 32'(rdy_cnt), 0);

`ifdef OBUFTDS_PRBS_EN
    // PRBS from reset seed: first words 0xF then 0xE on a 4-channel bank.
    cycle("prst", 1, 0, 1, 4'h0, 4'h0, 1);
    for (int n = 0; n < 4; n++) cycle("pwake", 0, 0, 0, 4'h0, 4'h0, 1);
    cycle("prbs", 0, 0, 0, 4'h0, 4'h0, 1);
    chk("prbs_w0", 32'(dut_obs().val), 32'hF);
    cycle("prbs", 0, 0, 0, 4'h0, 4'h0, 1);
    chk("prbs_w1", 32'(dut_obs().val), 32'hE);
    for (int n = 0; n < 20; n++) cycle("prbs", 0, 0, 0, 4'h0, 4'h0, 1);
`endif

    // Constrained-random traffic against the model.
    for (int n = 0; n < 120; n++) begin
      cycle("rnd",
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
            4'($urandom),
            1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
